exec_sequencer: RTL and testbench

//  Run-control FSM for the matrix processor. Owns the program counter and the execution enable.

---
 rtl/exec_sequencer_pkg.sv | 19 +
 rtl/exec_sequencer_watchdog.sv | 48 ++++
 rtl/exec_sequencer.sv | 155 +++++++++++++++
 tb/tb_exec_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared state encodings and width defaults for the execution sequencer.
package exec_sequencer_pkg;

   localparam int INSTR_BIT   = 8;
   localparam int SEQ_CNT_BIT = 16;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_HALT  = 2'd2,
      SEQ_PAUSE = 2'd3
   } seq_state_e;

   // A program is considered active while executing or parked between single steps.
   function automatic logic seq_is_active(input seq_state_e st);
      return (st == SEQ_RUN) || (st == SEQ_PAUSE);
   endfunction

endpackage

// File: rtl/exec_sequencer_watchdog.sv
// seq_watchdog: executed-instruction counter with clear, increment, saturation at
// MAX_CYCLES and a trip flag raised while the last budgeted instruction is current.
module seq_watchdog
   import exec_sequencer_pkg::*;
#(
   parameter int CNT_W      = SEQ_CNT_BIT,
   parameter int MAX_CYCLES = 65535
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             trip_o
);

   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear dominates, increment saturates at the budget.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + ONE_C;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign trip_o = (cnt_q == LAST_C);

endmodule

// File: rtl/exec_sequencer.sv
// Run-control FSM: owns the PC and the commit qualifier exec_en.
// Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int INSTR_W    = INSTR_BIT,
   parameter int CNT_W      = SEQ_CNT_BIT,
   parameter int MAX_CYCLES = 65535
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               St,
   input  logic               jump,
   input  logic               PC_src,
   input  logic [INSTR_W-1:0] jump_addr,
   input  logic               halt_instr,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic               step_mode,
   input  logic               step,
`endif
   output logic [INSTR_W-1:0] pc,
   output logic               exec_en,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [CNT_W-1:0]   cycles
);

   localparam logic [INSTR_W-1:0] PC_ONE_C = INSTR_W'(1);

   seq_state_e         state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic               wd_clr_s, wd_inc_s, wd_trip_s;
   logic               step_rise_s;
   logic               step_pause_s;

   seq_watchdog #(
      .CNT_W      (CNT_W),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_watchdog (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .clr_i  (wd_clr_s),
      .inc_i  (wd_inc_s),
      .cnt_o  (cycles),
      .trip_o (wd_trip_s)
   );

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q;

   // Previous step level for rising-edge detection.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step;
      end
   end

   assign step_rise_s  = step & ~step_q;
   assign step_pause_s = step_mode;
`else
   assign step_rise_s  = 1'b0;
   assign step_pause_s = 1'b0;
`endif

   // Next-state and register updates; halt beats the watchdog, which beats a normal step.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      busy_d    = busy_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      wd_clr_s  = 1'b0;
      wd_inc_s  = 1'b0;
      case (state_q)
         SEQ_IDLE, SEQ_HALT: begin
            if (St) begin
               state_d   = SEQ_RUN;
               pc_d      = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               wd_clr_s  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         SEQ_RUN: begin
            if (halt_instr) begin
               state_d = SEQ_HALT;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (wd_trip_s) begin
               state_d   = SEQ_HALT;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               wd_inc_s  = 1'b1;
            end else begin
               wd_inc_s = 1'b1;
               if (PC_src && jump) begin
                  pc_d = jump_addr;
               end else begin
                  pc_d = pc_q + PC_ONE_C;
               end
               if (step_pause_s) begin
                  state_d = SEQ_PAUSE;
               end else begin
                  state_d = SEQ_RUN;
               end
            end
         end
         SEQ_PAUSE: begin
            if (step_rise_s || !step_pause_s) begin
               state_d = SEQ_RUN;
            end else begin
               state_d = SEQ_PAUSE;
            end
         end
         default: begin
            state_d = SEQ_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= SEQ_IDLE;
         pc_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   assign exec_en = (state_q == SEQ_RUN) & ~halt_instr;
   assign pc      = pc_q;
   assign busy    = busy_q & seq_is_active(state_q);
   assign done    = done_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer (INSTR_W=4, MAX_CYCLES=10): stimulus pushes expected
// commits and completions, a negedge monitor pops and compares.
module tb_exec_sequencer;

   localparam int IW = 4;
   localparam int CW = 16;

   typedef struct packed {
      logic [IW-1:0] pc;
      logic [CW-1:0] cyc;
      logic          to;
   } done_t;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          St = 1'b0;
   logic          jump = 1'b0;
   logic          PC_src;
   logic [IW-1:0] jump_addr = '0;
   logic          halt_instr;
   logic [IW-1:0] pc;
   logic          exec_en, busy, done, timeout;
   logic [CW-1:0] cycles;
`ifdef SEQ_SINGLE_STEP_EN
   logic          step_mode = 1'b0;
   logic          step = 1'b0;
`endif

   logic          halt_en = 1'b0;
   logic [IW-1:0] halt_addr = '0;
   logic          br_en = 1'b0;
   logic [IW-1:0] br_addr = '0;

   int            checks = 0;
   int            errs = 0;
   logic [IW-1:0] exp_pc_q[$];
   done_t         exp_done_q[$];
   logic [IW-1:0] e_pc;
   done_t         e_done;
   logic          done_prev = 1'b0;

   exec_sequencer #(.INSTR_W(IW), .CNT_W(CW), .MAX_CYCLES(10)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .St         (St),
      .jump       (jump),
      .PC_src     (PC_src),
      .jump_addr  (jump_addr),
      .halt_instr (halt_instr),
`ifdef SEQ_SINGLE_STEP_EN
      .step_mode  (step_mode),
      .step       (step),
`endif
      .pc         (pc),
      .exec_en    (exec_en),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .cycles     (cycles)
   );

   always #5 CLK = ~CLK;

   // Tiny decoder model: halt / branch live at fixed addresses of the program.
   always_comb begin
      halt_instr = halt_en && (pc == halt_addr);
      PC_src     = br_en && (pc == br_addr);
   end

   // Monitor: every commit and every rising done is compared against the scoreboard.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (exec_en) begin
            checks++;
            if (exp_pc_q.size() == 0) begin
               errs++;
               $display("FAIL commit: unexpected commit at pc=%0d", pc);
            end else begin
               e_pc = exp_pc_q.pop_front();
               if (pc !== e_pc) begin
                  errs++;
                  $display("FAIL commit_pc: got %0d expected %0d", pc, e_pc);
               end
            end
         end
         if (done && !done_prev) begin
            checks++;
            if (exp_done_q.size() == 0) begin
               errs++;
               $display("FAIL done: unexpected completion pc=%0d cycles=%0d", pc, cycles);
            end else begin
               e_done = exp_done_q.pop_front();
               if (pc !== e_done.pc || cycles !== e_done.cyc || timeout !== e_done.to
                   || busy !== 1'b0) begin
                  errs++;
                  $display("FAIL done_state: got pc=%0d cyc=%0d to=%0b busy=%0b expected pc=%0d cyc=%0d to=%0b busy=0",
                           pc, cycles, timeout, busy, e_done.pc, e_done.cyc, e_done.to);
               end
            end
         end
      end
      done_prev <= done;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push_run(input int first, input int last);
      for (int a = first; a <= last; a++) exp_pc_q.push_back(IW'(a));
   endtask

   task automatic start_pulse();
      St = 1'b1;
      @(posedge CLK); #1;
      St = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge CLK);
         n++;
      end
      @(posedge CLK); #1;
      checks++;
      if (!done) begin
         errs++;
         $display("FAIL %s: no done within %0d cycles", name, budget);
      end
      check({name, "_drained"}, 32'(exp_pc_q.size() + exp_done_q.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_cycles", 32'(cycles), 32'd0);
      check("rst_flags", {28'd0, exec_en, busy, done, timeout}, 32'd0);
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;

      // Halt at address 3
      halt_en = 1'b1; halt_addr = 4'd3;
      push_run(0, 2);
      exp_done_q.push_back('{pc: 4'd3, cyc: 16'd3, to: 1'b0});
      start_pulse();
      check("run_busy", 32'(busy), 32'd1);
      wait_done("halt3", 40);

      // Taken branch at 2 -> 7, halt at 9
      halt_addr = 4'd9; br_en = 1'b1; br_addr = 4'd2; jump_addr = 4'd7; jump = 1'b1;
      push_run(0, 2); push_run(7, 8);
      exp_done_q.push_back('{pc: 4'd9, cyc: 16'd5, to: 1'b0});
      start_pulse();
      wait_done("jump_taken", 40);

      // Same program with jump disabled; halt at cycles==MAX-1 beats the watchdog
      jump = 1'b0;
      push_run(0, 8);
      exp_done_q.push_back('{pc: 4'd9, cyc: 16'd9, to: 1'b0});
      start_pulse();
      wait_done("jump_off", 40);

      // Self-jump spin loop ended by the watchdog
      halt_en = 1'b0; br_addr = 4'd4; jump_addr = 4'd4; jump = 1'b1;
      push_run(0, 4); push_run(4, 4); push_run(4, 4); push_run(4, 4); push_run(4, 4); push_run(4, 4);
      exp_done_q.push_back('{pc: 4'd4, cyc: 16'd10, to: 1'b1});
      start_pulse();
      wait_done("watchdog", 40);
      check("wd_cycles_hold", 32'(cycles), 32'd10);

      // Restart after timeout
      halt_en = 1'b1; halt_addr = 4'd1; br_en = 1'b0; jump = 1'b0;
      push_run(0, 0);
      exp_done_q.push_back('{pc: 4'd1, cyc: 16'd1, to: 1'b0});
      start_pulse();
      check("restart_pc", 32'(pc), 32'd0);
      check("restart_flags", {29'd0, done, timeout, busy}, 32'd1);
      wait_done("restart", 40);

      // PC wrap 13,14,15,0,1 with St held high through the run
      halt_addr = 4'd3; br_en = 1'b1; br_addr = 4'd0; jump_addr = 4'd13; jump = 1'b1;
      push_run(0, 0); push_run(13, 15); push_run(0, 2);
      exp_done_q.push_back('{pc: 4'd3, cyc: 16'd7, to: 1'b0});
      St = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      jump = 1'b0;
      check("wrap_pc13", 32'(pc), 32'd13);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("wrap_st_ignored_pc", 32'(pc), 32'd15);
      St = 1'b0;
      wait_done("wrap", 40);

      // Asynchronous reset mid-run at pc=5
      halt_en = 1'b0; br_en = 1'b0;
      push_run(0, 5);
      start_pulse();
      for (int n = 0; n < 20 && pc != 4'd5; n++) begin
         @(posedge CLK); #1;
      end
      check("pre_reset_pc", 32'(pc), 32'd5);
      @(negedge CLK); #1;
      RST_N = 1'b0;
      #1;
      check("async_rst_pc", 32'(pc), 32'd0);
      check("async_rst_flags", {28'd0, busy, done, timeout, exec_en}, 32'd0);
      check("async_rst_cycles", 32'(cycles), 32'd0);
      @(negedge CLK); RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("post_rst_idle", {30'd0, busy, pc == 4'd0}, 32'd1);
      check("post_rst_drained", 32'(exp_pc_q.size()), 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
      // Single step: one commit per step rising edge
      step_mode = 1'b1;
      push_run(0, 0);
      start_pulse();
      repeat (3) @(posedge CLK);
      #1;
      check("step_pause_pc", 32'(pc), 32'd1);
      check("step_pause_busy", {30'd0, busy, exec_en}, 32'd2);
      for (int k = 1; k <= 3; k++) begin
         exp_pc_q.push_back(IW'(k));
         step = 1'b1;
         repeat (2) @(posedge CLK);
         #1;
         step = 1'b0;
         repeat (2) @(posedge CLK);
         #1;
         check("step_pc", 32'(pc), 32'(k + 1));
      end
      check("step_cycles", 32'(cycles), 32'd4);
      check("step_drained", 32'(exp_pc_q.size()), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
